// File: rtl/regbank_pkg.sv
// Shared constants, address helper and address type for the register bank.
package regbank_pkg;

  localparam int DEFAULT_W     = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Smallest r with 2**r >= n; sizes the address bus for any entry count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEFAULT_AW = clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0] addr_t;

endpackage

// File: rtl/reg_cell.sv
// Single W-bit storage register with synchronous reset and load enable.
module reg_cell #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // Next value: load when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Storage flop; reset wins over any load.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VALUE;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/register_bank.sv
// Addressable register bank: one write port, two combinational read ports,
// optional write-first bypass, optional hardwired-zero entry 0 and a per-entry
// busy scoreboard for read-after-write hazard detection.
module register_bank
  import regbank_pkg::*;
#(
  parameter int           W         = DEFAULT_W,
  parameter int           DEPTH     = DEFAULT_DEPTH,
  parameter int           AW        = clog2(DEPTH),
  parameter logic [W-1:0] RST_VALUE = '0,
  parameter bit           ZERO_REG  = 1'b1,
  parameter bit           BYPASS    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd2,
  input  logic          set_busy,
  input  logic [AW-1:0] busy_addr,
  output logic          busy1,
  output logic          busy2
);

  // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic               we_ok;
  logic               set_ok;
  logic [DEPTH-1:0]   we_dec;
  logic [DEPTH-1:0]   set_dec;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [W-1:0]       entry_q [DEPTH];

  // An address is writable when it is in range and not the hardwired zero.
  always_comb begin
    we_ok  = we && ({1'b0, wa} < DEPTH_L) && !(ZERO_REG && (wa == '0));
    set_ok = set_busy && ({1'b0, busy_addr} < DEPTH_L)
             && !(ZERO_REG && (busy_addr == '0));
  end

  // One-hot write and busy-set decode.
  always_comb begin
    we_dec  = '0;
    set_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we_dec[i]  = we_ok  && (wa == AW'(i));
      set_dec[i] = set_ok && (busy_addr == AW'(i));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (ZERO_REG && (gi == 0)) begin : g_zero
        assign entry_q[gi] = '0;
      end else begin : g_cell
        reg_cell #(
          .W         (W),
          .RST_VALUE (RST_VALUE)
        ) u_cell (
          .clk (clk),
          .rst (rst),
          .en  (we_dec[gi]),
          .d   (wd),
          .q   (entry_q[gi])
        );
      end
    end
  endgenerate

  // Busy next state: a write retires the producer, a new set overrides it.
  always_comb begin
    busy_d = (busy_q & ~we_dec) | set_dec;
  end

  // Busy scoreboard flops; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read port 1: stored value (0 when out of range), then write-first bypass.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra1 == AW'(i)) begin
        rd1   = entry_q[i];
        busy1 = busy_q[i];
      end
    end
    if (BYPASS && we_ok && (wa == ra1)) begin
      rd1   = wd;
      busy1 = 1'b0;
    end
  end

  // Read port 2: identical path to port 1.
  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra2 == AW'(i)) begin
        rd2   = entry_q[i];
        busy2 = busy_q[i];
      end
    end
    if (BYPASS && we_ok && (wa == ra2)) begin
      rd2   = wd;
      busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank across four parameter sets sharing inputs.
module tb_register_bank;

  localparam logic [31:0] RST_D = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        set_busy = 1'b0;
  logic [4:0]  busy_addr = '0;

  logic [7:0]  r_rd1, r_rd2;
  logic        r_b1, r_b2;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2, d_rd1, d_rd2;
  logic        b_b1, b_b2, n_b1, n_b2, d_b1, d_b2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_bank #(.W(8), .RST_VALUE(8'hA5)) dut_r (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd[7:0]),
    .ra1(ra1), .rd1(r_rd1), .ra2(ra2), .rd2(r_rd2),
    .set_busy(set_busy), .busy_addr(busy_addr), .busy1(r_b1), .busy2(r_b2));

  register_bank #(.W(32), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .rd1(b_rd1), .ra2(ra2), .rd2(b_rd2),
    .set_busy(set_busy), .busy_addr(busy_addr), .busy1(b_b1), .busy2(b_b2));

  register_bank #(.W(32), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .rd1(n_rd1), .ra2(ra2), .rd2(n_rd2),
    .set_busy(set_busy), .busy_addr(busy_addr), .busy1(n_b1), .busy2(n_b2));

  register_bank #(.W(32), .DEPTH(20), .RST_VALUE(RST_D)) dut_d (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .rd1(d_rd1), .ra2(ra2), .rd2(d_rd2),
    .set_busy(set_busy), .busy_addr(busy_addr), .busy1(d_b1), .busy2(d_b2));

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; set_busy = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp8;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      exp8 = (a == 0) ? 8'h00 : 8'hA5;
      tests++;
      if (r_rd1 !== exp8) begin
        fails++; $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, r_rd1, exp8);
      end
      exp8 = (a == 31) ? 8'h00 : 8'hA5;
      tests++;
      if (r_rd2 !== exp8) begin
        fails++; $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, r_rd2, exp8);
      end
      tests++;
      if ({r_b1, r_b2, b_b1, b_b2} !== 4'b0000) begin
        fails++; $display("FAIL reset_busy addr=%0d got=%b exp=0000", a, {r_b1, r_b2, b_b1, b_b2});
      end
    end
  endtask

  task automatic test_write_read();
    ra1 = 5'd0; ra2 = 5'd0;
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    tests++;
    if (b_rd1 !== 32'hDEAD_BEEF || b_rd2 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL write_read_byp got=%h/%h exp=deadbeef", b_rd1, b_rd2);
    end
    tests++;
    if (n_rd1 !== 32'hDEAD_BEEF || n_rd2 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL write_read_nobyp got=%h/%h exp=deadbeef", n_rd1, n_rd2);
    end
  endtask

  task automatic test_bypass();
    ra1 = 5'd7; ra2 = 5'd5;
    we = 1'b1; wa = 5'd7; wd = 32'h0000_1234;
    #1;
    tests++;
    if (b_rd1 !== 32'h0000_1234 || b_b1 !== 1'b0) begin
      fails++; $display("FAIL bypass_same_cycle got=%h exp=00001234", b_rd1);
    end
    tests++;
    if (n_rd1 !== 32'h0000_0000) begin
      fails++; $display("FAIL nobypass_old got=%h exp=00000000", n_rd1);
    end
    tests++;
    if (b_rd2 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL bypass_other_port got=%h exp=deadbeef", b_rd2);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (n_rd1 !== 32'h0000_1234 || b_rd1 !== 32'h0000_1234) begin
      fails++; $display("FAIL bypass_after_edge got=%h/%h exp=00001234", n_rd1, b_rd1);
    end
  endtask

  task automatic test_zero();
    ra1 = 5'd0; ra2 = 5'd0;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    set_busy = 1'b1; busy_addr = 5'd0;
    #1;
    tests++;
    if (b_rd1 !== 32'h0 || b_b1 !== 1'b0) begin
      fails++; $display("FAIL zero_same_cycle got=%h busy=%b exp=0", b_rd1, b_b1);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (b_rd1 !== 32'h0 || n_rd2 !== 32'h0 || d_rd1 !== 32'h0) begin
        fails++; $display("FAIL zero_rd cyc=%0d got=%h/%h/%h exp=0", c, b_rd1, n_rd2, d_rd1);
      end
      tests++;
      if ({b_b1, n_b1, d_b2} !== 3'b000) begin
        fails++; $display("FAIL zero_busy cyc=%0d got=%b exp=000", c, {b_b1, n_b1, d_b2});
      end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    set_busy = 1'b1; busy_addr = 5'd3;
    ra1 = 5'd3; ra2 = 5'd4;
    tick();
    set_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (b_b1 !== 1'b1 || n_b1 !== 1'b1 || b_b2 !== 1'b0) begin
        fails++; $display("FAIL sb_busy cyc=%0d got=%b%b%b exp=110", c, b_b1, n_b1, b_b2);
      end
      tick();
    end
    we = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
    #1;
    tests++;
    if (b_b1 !== 1'b0 || n_b1 !== 1'b1) begin
      fails++; $display("FAIL sb_write_same_cycle got=%b%b exp=01", b_b1, n_b1);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (n_b1 !== 1'b0 || b_b1 !== 1'b0 || n_rd1 !== 32'h33) begin
      fails++; $display("FAIL sb_cleared got=%b%b rd=%h exp=00/33", n_b1, b_b1, n_rd1);
    end
    we = 1'b1; wa = 5'd3; wd = 32'h0000_0044;
    set_busy = 1'b1; busy_addr = 5'd3;
    tick();
    idle();
    #1;
    tests++;
    if (b_b1 !== 1'b1 || n_b1 !== 1'b1) begin
      fails++; $display("FAIL sb_set_wins got=%b%b exp=11", b_b1, n_b1);
    end
    tests++;
    if (b_rd1 !== 32'h44 || n_rd1 !== 32'h44) begin
      fails++; $display("FAIL sb_set_data got=%h/%h exp=44", b_rd1, n_rd1);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wa = 5'd25; wd = 32'hCAFE_F00D;
    set_busy = 1'b1; busy_addr = 5'd25;
    ra1 = 5'd25; ra2 = 5'd25;
    #1;
    tests++;
    if (d_rd1 !== 32'h0 || d_b1 !== 1'b0) begin
      fails++; $display("FAIL oor_same_cycle got=%h busy=%b exp=0", d_rd1, d_b1);
    end
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      #1;
      exp = (a == 0 || a >= 20) ? 32'h0 : RST_D;
      tests++;
      if (d_rd1 !== exp || d_rd2 !== exp || d_b1 !== 1'b0 || d_b2 !== 1'b0) begin
        fails++; $display("FAIL oor_sweep addr=%0d got=%h busy=%b exp=%h", a, d_rd1, d_b1, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_busy = 1'b1; busy_addr = 5'd6;
    tick();
    set_busy = 1'b0; ra2 = 5'd6;
    #1;
    tests++;
    if (d_b2 !== 1'b1 || b_b2 !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre_busy got=%b%b exp=11", d_b2, b_b2);
    end
    rst = 1'b1;
    we = 1'b1; wa = 5'd4; wd = 32'h0000_BEEF;
    set_busy = 1'b1; busy_addr = 5'd9;
    tick();
    idle();
    ra1 = 5'd4; ra2 = 5'd6;
    #1;
    tests++;
    if (d_rd1 !== RST_D || b_rd1 !== 32'h0) begin
      fails++; $display("FAIL rstmid_data got=%h/%h exp=%h/0", d_rd1, b_rd1, RST_D);
    end
    tests++;
    if (d_b2 !== 1'b0 || b_b2 !== 1'b0) begin
      fails++; $display("FAIL rstmid_busy6 got=%b%b exp=00", d_b2, b_b2);
    end
    ra2 = 5'd9;
    #1;
    tests++;
    if (d_b2 !== 1'b0 || b_b2 !== 1'b0) begin
      fails++; $display("FAIL rstmid_busy9 got=%b%b exp=00", d_b2, b_b2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
